// File: rtl/aurora_pkg.sv
// Shared types and widths for the Aurora RX stream demultiplexer.
// Holds the frame FSM state and the 37-bit beat payload layout.
package aurora_pkg;

    localparam int ETH_MAX    = 8;
    localparam int ETH_IDX_W  = 3;
    localparam int AXIS_DW    = 32;
    localparam int AXIS_KW    = 4;
    localparam int AXIS_PW    = AXIS_DW + AXIS_KW + 1;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [AXIS_DW-1:0] data;
        logic [AXIS_KW-1:0] keep;
        logic               last;
    } axis_beat_t;

endpackage

// File: rtl/aurora_axis_reg_slice.sv
// One-entry registered AXIS stage; one cycle load-to-valid.
// Upstream loads only when the slot is empty or draining this cycle; fields hold while stalled.
module aurora_axis_reg_slice
    import aurora_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_vld,
    input  logic [AXIS_PW-1:0] load_dat,
    input  logic               out_rdy,
    output logic               out_vld,
    output logic [AXIS_PW-1:0] out_dat
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (load_vld) begin
            out_vld <= 1'b1;
            out_dat <= load_dat;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/aurora_axi_rx_demux.sv
// Routes whole AXIS frames to one of ETHCOUNT channels by the first-beat sel; 1-cycle latency.
// Upstream ready follows the target slot; frames to missing channels are swallowed and counted.
module aurora_axi_rx_demux
    import aurora_pkg::*;
#(
    parameter int ETHCOUNT = 4,
    parameter int SIM      = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ETH_IDX_W-1:0]        axis_m_sel,
    output logic                        axis_s_tready,
    input  logic [AXIS_DW-1:0]          axis_s_tdata,
    input  logic [AXIS_KW-1:0]          axis_s_tkeep,
    input  logic                        axis_s_tvalid,
    input  logic                        axis_s_tlast,
    input  logic [ETHCOUNT-1:0]         axis_m_tready,
    output logic [ETHCOUNT*AXIS_DW-1:0] axis_m_tdata,
    output logic [ETHCOUNT*AXIS_KW-1:0] axis_m_tkeep,
    output logic [ETHCOUNT-1:0]         axis_m_tvalid,
    output logic [ETHCOUNT-1:0]         axis_m_tlast,
    output logic [DROP_CNT_W-1:0]       stat_drop_cnt,
    output logic                        err_sel_invalid
);

    state_t               state_q, state_nx;
    logic [ETH_IDX_W-1:0] cur_ch;
    logic [ETH_IDX_W-1:0] route_ch;
    logic                 sel_ok;
    logic                 route_vld;
    logic                 accept;
    logic                 drop_start;
    logic [ETH_MAX-1:0]   vld_pad, rdy_pad;
    logic [ETHCOUNT-1:0]  load;
    axis_beat_t           in_beat;

    if (SIM != 0) begin : g_sim_build
    end

    assign vld_pad  = ETH_MAX'(axis_m_tvalid);
    assign rdy_pad  = ETH_MAX'(axis_m_tready);
    assign sel_ok   = (4'(axis_m_sel) < 4'(ETHCOUNT));
    assign route_ch = (state_q == PASS) ? cur_ch : axis_m_sel;
    assign in_beat  = '{data: axis_s_tdata, keep: axis_s_tkeep, last: axis_s_tlast};
    assign accept   = axis_s_tvalid & axis_s_tready;

    // Ready never looks at tvalid, so upstream can't form a comb loop through us.
    always_comb begin
        axis_s_tready = 1'b0;
        route_vld     = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    route_vld     = sel_ok;
                    axis_s_tready = sel_ok ? (!vld_pad[axis_m_sel] | rdy_pad[axis_m_sel]) : 1'b1;
                end
                PASS: begin
                    route_vld     = 1'b1;
                    axis_s_tready = !vld_pad[cur_ch] | rdy_pad[cur_ch];
                end
                DROP: axis_s_tready = 1'b1;
                default: axis_s_tready = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_nx   = state_q;
        drop_start = 1'b0;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (sel_ok) begin
                        state_nx = axis_s_tlast ? IDLE : PASS;
                    end else begin
                        drop_start = 1'b1;
                        state_nx   = axis_s_tlast ? IDLE : DROP;
                    end
                end
                PASS, DROP: if (axis_s_tlast) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cur_ch          <= '0;
            err_sel_invalid <= 1'b0;
            stat_drop_cnt   <= '0;
        end else begin
            state_q         <= state_nx;
            err_sel_invalid <= drop_start;
            if (accept && state_q == IDLE) begin
                cur_ch <= axis_m_sel;
            end
            if (drop_start && stat_drop_cnt != {DROP_CNT_W{1'b1}}) begin
                stat_drop_cnt <= stat_drop_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < ETHCOUNT; i++) begin : g_ch
        logic [AXIS_PW-1:0] slice_dat;
        axis_beat_t         out_beat;

        assign load[i] = accept & route_vld & (route_ch == ETH_IDX_W'(i));

        aurora_axis_reg_slice u_slice (
            .clk      (clk),
            .rst      (rst),
            .load_vld (load[i]),
            .load_dat (in_beat),
            .out_rdy  (axis_m_tready[i]),
            .out_vld  (axis_m_tvalid[i]),
            .out_dat  (slice_dat)
        );

        assign out_beat                            = slice_dat;
        assign axis_m_tdata[i*AXIS_DW +: AXIS_DW]  = out_beat.data;
        assign axis_m_tkeep[i*AXIS_KW +: AXIS_KW]  = out_beat.keep;
        assign axis_m_tlast[i]                     = out_beat.last;
    end

endmodule
